// File: rtl/dest_drain_pkg.sv
// Shared types and constants for the destination drain.
// FSM states, default widths and header bit positions.
package dest_drain_pkg;

  localparam int DATA_W_DEF = 6;
  localparam int CNT_W_DEF  = 8;

  localparam int VC_BIT   = DATA_W_DEF - 1;
  localparam int DEST_BIT = DATA_W_DEF - 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_WAIT,
    S_HOLD
  } state_t;

  function automatic int vc_idx(input int w);
    return w - 1;
  endfunction

  function automatic int dest_idx(input int w);
    return w - 2;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter.
// Ports: req (2), upd (advance), gnt one-hot (2), ptr (1 = favour D1).
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt,
  output logic       ptr
);

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11): gnt = ptr ? 2'b10 : 2'b01;
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default:        gnt = 2'b00;
    endcase
  end

  // After a grant the other source is favoured, so
  // ~ptr names the source just granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (upd) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/dest_drain.sv
// Drains two destination FIFOs into one registered output stream.
// Ports: empties/read data in, pop strobes, drained word, counters, flags.
module dest_drain
  import dest_drain_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              empty_D0,
  input  logic              empty_D1,
  input  logic [DATA_W-1:0] data_out0,
  input  logic [DATA_W-1:0] data_out1,
  output logic              pop_D0,
  output logic              pop_D1,
  input  logic              ready_in,
  output logic [DATA_W-1:0] data_drain,
  output logic              valid_drain,
  output logic [CNT_W-1:0]  cnt_D0,
  output logic [CNT_W-1:0]  cnt_D1,
  output logic              idle_drain,
  output logic              error_drain
);

  localparam int DB = dest_idx(DATA_W);

  state_t            state;
  state_t            nxt;
  logic              go_pop;
  logic              any;
  logic [1:0]        gnt;
  logic              ptr;
  logic              src;
  logic [DATA_W-1:0] word;

  assign any  = ~empty_D0 | ~empty_D1;
  // Pointer moves on the pop decision, so it
  // identifies the in-flight source until the next pop.
  assign src  = ~ptr;
  assign word = src ? data_out1 : data_out0;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({~empty_D1, ~empty_D0}),
    .upd   (go_pop),
    .gnt   (gnt),
    .ptr   (ptr)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (any) nxt = S_POP;
      S_POP:  nxt = S_WAIT;
      S_WAIT: nxt = S_HOLD;
      S_HOLD: begin
        if (ready_in) nxt = any ? S_POP : S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign go_pop = (nxt == S_POP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pop_D0      <= 1'b0;
      pop_D1      <= 1'b0;
      data_drain  <= '0;
      cnt_D0      <= '0;
      cnt_D1      <= '0;
      error_drain <= 1'b0;
    end else begin
      state  <= nxt;
      pop_D0 <= go_pop & gnt[0];
      pop_D1 <= go_pop & gnt[1];
      if (state == S_WAIT) begin
        data_drain <= word;
        if (word[DB] != src) error_drain <= 1'b1;
      end
      if (state == S_HOLD && ready_in) begin
        if (src) cnt_D1 <= cnt_D1 + CNT_W'(1);
        else     cnt_D0 <= cnt_D0 + CNT_W'(1);
      end
    end
  end

  assign valid_drain = (state == S_HOLD);
  assign idle_drain  = (state == S_IDLE) & empty_D0 & empty_D1;

endmodule

// File: tb/tb_dest_drain.sv
// Bench for dest_drain: FIFO models, reference scoreboard,
// directed cases and a randomized phase.
module tb_dest_drain;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       empty_D0 = 1'b1;
  logic       empty_D1 = 1'b1;
  logic [5:0] data_out0 = '0;
  logic [5:0] data_out1 = '0;
  logic       pop_D0;
  logic       pop_D1;
  logic       ready_in = 1'b0;
  logic [5:0] data_drain;
  logic       valid_drain;
  logic [7:0] cnt_D0;
  logic [7:0] cnt_D1;
  logic       idle_drain;
  logic       error_drain;

  logic       push0 = 1'b0;
  logic       push1 = 1'b0;
  logic [5:0] push0_d = '0;
  logic [5:0] push1_d = '0;

  logic [5:0] q0[$];
  logic [5:0] q1[$];

  int n_chk = 0;
  int n_bad = 0;

  dest_drain dut (
    .clk         (clk),
    .reset       (reset),
    .empty_D0    (empty_D0),
    .empty_D1    (empty_D1),
    .data_out0   (data_out0),
    .data_out1   (data_out1),
    .pop_D0      (pop_D0),
    .pop_D1      (pop_D1),
    .ready_in    (ready_in),
    .data_drain  (data_drain),
    .valid_drain (valid_drain),
    .cnt_D0      (cnt_D0),
    .cnt_D1      (cnt_D1),
    .idle_drain  (idle_drain),
    .error_drain (error_drain)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // FIFO models: read data appears the cycle after a pop.
  always @(posedge clk) begin
    if (reset) begin
      q0.delete();
      q1.delete();
    end else begin
      if (pop_D0 && q0.size() > 0) data_out0 <= q0.pop_front();
      if (pop_D1 && q1.size() > 0) data_out1 <= q1.pop_front();
      if (push0) q0.push_back(push0_d);
      if (push1) q1.push_back(push1_d);
    end
    empty_D0 <= (q0.size() == 0);
    empty_D1 <= (q1.size() == 0);
  end

  // Reference model / scoreboard, sampled on the falling edge.
  int         cyc = 0;
  int         cm0 = 0;
  int         cm1 = 0;
  bit         err_m = 0;
  bit         fav = 0;
  bit         pe0 = 1;
  bit         pe1 = 1;
  bit         pv = 0;
  bit         pr = 0;
  logic [5:0] pd = '0;
  logic [5:0] exp_w = '0;
  int         pop_cyc = 0;
  bit         pop_src = 0;
  int         pops = 0;
  logic [5:0] acc_q[$];
  bit         pop_log[$];

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      cm0 = 0;
      cm1 = 0;
      err_m = 0;
      fav = 0;
      pv = 0;
    end else begin
      chk("cnt_D0", cnt_D0, cm0 % 256);
      chk("cnt_D1", cnt_D1, cm1 % 256);
      if (pop_D0 || pop_D1) begin
        chk("pop_excl", pop_D0 & pop_D1, 0);
        pop_src = pop_D1;
        if (pop_src) chk("pop1_empty", empty_D1, 0);
        else         chk("pop0_empty", empty_D0, 0);
        if (!pe0 && !pe1) chk("rr_both", pop_src, fav);
        else              chk("rr_single", pop_src, pe0);
        fav = !pop_src;
        if (pop_src) exp_w = (q1.size() > 0) ? q1[0] : 6'h0;
        else         exp_w = (q0.size() > 0) ? q0[0] : 6'h0;
        pop_cyc = cyc;
        pops++;
        pop_log.push_back(pop_src);
        if (pv && !pr) chk("pop_in_hold", 1, 0);
      end
      if (valid_drain && !pv) begin
        chk("latency", cyc - pop_cyc, 2);
        chk("data", data_drain, exp_w);
      end
      if (valid_drain && pv && !pr)
        chk("stable", data_drain, pd);
      if (valid_drain && ready_in) begin
        if (data_drain[4] != pop_src) err_m = 1;
        chk("error", error_drain, err_m);
        if (pop_src) cm1++;
        else         cm0++;
        acc_q.push_back(data_drain);
      end
      pv = valid_drain;
    end
    pr = ready_in;
    pd = data_drain;
    pe0 = empty_D0;
    pe1 = empty_D1;
  end

  task automatic push(input bit f, input logic [5:0] d);
    @(posedge clk); #1;
    if (f) begin push1 = 1; push1_d = d; end
    else   begin push0 = 1; push0_d = d; end
    @(posedge clk); #1;
    push0 = 0;
    push1 = 0;
  endtask

  task automatic push2(input logic [5:0] d0,
                       input logic [5:0] d1);
    @(posedge clk); #1;
    push0 = 1; push0_d = d0;
    push1 = 1; push1_d = d1;
    @(posedge clk); #1;
    push0 = 0;
    push1 = 0;
  endtask

  task automatic wait_idle(input int max);
    for (int n = 0; n < max && !idle_drain; n++)
      @(negedge clk);
    @(negedge clk);
    chk("idle_wait", idle_drain, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pop0", pop_D0, 0);
    chk("rst_pop1", pop_D1, 0);
    chk("rst_valid", valid_drain, 0);
    chk("rst_data", data_drain, 0);
    chk("rst_cnt0", cnt_D0, 0);
    chk("rst_cnt1", cnt_D1, 0);
    chk("rst_err", error_drain, 0);
    chk("rst_idle", idle_drain, 1);
    @(posedge clk); #1;
    reset = 0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("quiet_idle", idle_drain, 1);
      chk("quiet_pop", pop_D0 | pop_D1, 0);
    end

    // Ordered drain across both sources.
    acc_q.delete();
    pop_log.delete();
    ready_in = 1;
    push2(6'b011011, 6'b111011);
    push(0, 6'b000011);
    wait_idle(60);
    chk("seq_len", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      chk("seq_w0", acc_q[0], 6'b011011);
      chk("seq_w1", acc_q[1], 6'b111011);
      chk("seq_w2", acc_q[2], 6'b000011);
    end
    if (pop_log.size() == 3) begin
      chk("seq_p0", pop_log[0], 0);
      chk("seq_p1", pop_log[1], 1);
      chk("seq_p2", pop_log[2], 0);
    end
    chk("seq_cnt0", cnt_D0, 2);
    chk("seq_cnt1", cnt_D1, 1);

    // Backpressure in HOLD.
    @(posedge clk); #1;
    ready_in = 0;
    push(0, 6'b001010);
    for (int n = 0; n < 20 && !valid_drain; n++)
      @(negedge clk);
    chk("hold_valid_wait", valid_drain, 1);
    repeat (5) @(negedge clk);
    chk("hold_valid", valid_drain, 1);
    chk("hold_data", data_drain, 6'b001010);
    chk("hold_pops", pops, 4);
    chk("hold_cnt0", cnt_D0, 2);
    @(posedge clk); #1;
    ready_in = 1;
    wait_idle(20);
    chk("hold_cnt0_after", cnt_D0, 3);

    // Reset while the word is in WAIT.
    push(0, 6'b000111);
    for (int n = 0; n < 20 && !pop_D0; n++)
      @(negedge clk);
    chk("rstw_pop_wait", pop_D0, 1);
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    chk("rstw_valid", valid_drain, 0);
    chk("rstw_cnt0", cnt_D0, 0);
    chk("rstw_cnt1", cnt_D1, 0);
    chk("rstw_err", error_drain, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rstw_idle", idle_drain, 1);
    @(posedge clk); #1;
    reset = 0;

    // Destination-bit checking.
    push(0, 6'b101101);
    wait_idle(20);
    chk("err_a_cnt0", cnt_D0, 1);
    chk("err_a_flag", error_drain, err_m);
    push(0, 6'b011101);
    wait_idle(20);
    chk("err_b_flag", error_drain, 1);
    chk("err_b_cnt0", cnt_D0, 2);
    chk("err_b_data", data_drain, 6'b011101);
    push(0, 6'b000001);
    wait_idle(20);
    chk("err_sticky", error_drain, 1);

    // D1 counter wrap.
    for (int i = 0; i < 255; i++) begin
      @(posedge clk); #1;
      push1 = 1;
      push1_d = {2'b01, 4'(i)};
    end
    @(posedge clk); #1;
    push1 = 0;
    wait_idle(1000);
    chk("wrap_255", cnt_D1, 255);
    push(1, 6'b010000);
    wait_idle(20);
    chk("wrap_0", cnt_D1, 0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      logic [5:0] d;
      @(posedge clk); #1;
      ready_in = ($urandom % 10) < 7;
      d = 6'($urandom);
      d[4] = (($urandom % 8) == 0);
      push0 = (q0.size() < 6) && (($urandom % 3) == 0);
      push0_d = d;
      d = 6'($urandom);
      d[4] = (($urandom % 8) != 0);
      push1 = (q1.size() < 6) && (($urandom % 3) == 0);
      push1_d = d;
    end
    @(posedge clk); #1;
    push0 = 0;
    push1 = 0;
    ready_in = 1;
    wait_idle(200);
    chk("rand_q0", q0.size(), 0);
    chk("rand_q1", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
